// File: rtl/bp_pkg.sv
// Shared branch-prediction helpers: counter constants, PC index extraction
// and the resolved EX-stage result record.
package bp_pkg;

    // Widest counter the BHT is built for.
    localparam int CNTR_BITS_MAX = 4;

    // Weakly-not-taken value: 2^(cbits-1)-1, which is 0 for a 1-bit counter.
    function automatic int cntr_wnt(input int cbits);
        return (1 << (cbits - 1)) - 1;
    endfunction

    // Strongly-taken ceiling of a cbits-wide saturating counter.
    function automatic int cntr_max(input int cbits);
        return (1 << cbits) - 1;
    endfunction

    // Table index: word-aligned PC bits [ibits+1:2]; the caller truncates.
    function automatic logic [63:0] bht_index(input logic [63:0] pc, input int ibits);
        return (pc >> 2) & ((64'd1 << ibits) - 64'd1);
    endfunction

    // Resolved outcome of the EX-stage instruction.
    typedef struct packed {
        logic decision;
        logic mispredict;
        logic train;
    } ex_res_t;

endpackage

// File: rtl/sat_counter.sv
// Next-state function of one saturating up/down counter (combinational).
module sat_counter
    import bp_pkg::*;
#(
    parameter int CNTR_BITS = 2
) (
    input  logic [CNTR_BITS-1:0] cur,
    input  logic                 inc,
    output logic [CNTR_BITS-1:0] nxt
);

    localparam logic [CNTR_BITS-1:0] MAX = CNTR_BITS'(cntr_max(CNTR_BITS));

    // Step toward taken or not-taken, holding at either end.
    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != MAX) nxt = cur + CNTR_BITS'(1);
        end else begin
            if (cur != '0) nxt = cur - CNTR_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT of saturating counters: IF-stage prediction, EX-stage
// resolution, table training and saturating performance counters.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNTR_BITS  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic                  pred_taken,
    input  logic                  ex_valid,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic                  ex_branch,
    input  logic                  ex_jump,
    input  logic                  ex_branch_enable,
    input  logic                  ex_predicted,
    output logic                  decision,
    output logic                  branch_jump_trigger,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] branch_cnt,
    output logic [STAT_WIDTH-1:0] mispredict_cnt
);

    localparam int NUM_ENTRIES = 1 << INDEX_BITS;
    localparam logic [CNTR_BITS-1:0] WNT = CNTR_BITS'(cntr_wnt(CNTR_BITS));

    // Inline flops so the async reset reaches every entry.
    logic [CNTR_BITS-1:0]  bht [NUM_ENTRIES];
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [CNTR_BITS-1:0]  ex_cur;
    logic [CNTR_BITS-1:0]  ex_nxt;
    ex_res_t               res;

    assign fetch_idx = INDEX_BITS'(bht_index(64'(fetch_pc), INDEX_BITS));
    assign ex_idx    = INDEX_BITS'(bht_index(64'(ex_pc), INDEX_BITS));

    // Zero-latency read; a same-cycle write to this entry shows up next cycle.
    assign pred_taken = bht[fetch_idx][CNTR_BITS-1];
    assign ex_cur     = bht[ex_idx];

    // Resolve the EX instruction; a jump wins over a branch and never trains.
    always_comb begin
        res.decision   = ex_valid & ((ex_branch & ex_branch_enable) | ex_jump);
        res.mispredict = ex_valid & (ex_predicted != res.decision);
        res.train      = ex_valid & ex_branch & ~ex_jump;
    end

    assign decision            = res.decision;
    assign branch_jump_trigger = res.decision;
    assign mispredict          = res.mispredict;

    sat_counter #(
        .CNTR_BITS (CNTR_BITS)
    ) u_sat_counter (
        .cur (ex_cur),
        .inc (ex_branch_enable),
        .nxt (ex_nxt)
    );

    // Table: every entry back to weakly-not-taken on reset, else train one entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) bht[i] <= WNT;
        end else if (res.train) begin
            bht[ex_idx] <= ex_nxt;
        end
    end

    // Performance counters, sticky at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (res.train && branch_cnt != '1)
                branch_cnt <= branch_cnt + STAT_WIDTH'(1);
            if (res.mispredict && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + STAT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomised + directed bench for branch_predictor_bht against an
// integer-array reference model of the prediction table.
module tb_branch_predictor_bht;

    localparam int PW   = 32;
    localparam int IB   = 6;
    localparam int CB   = 2;
    localparam int SW   = 4;
    localparam int NENT = 1 << IB;
    localparam int CMAX = (1 << CB) - 1;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] fetch_pc;
    logic          pred_taken;
    logic          ex_valid;
    logic [PW-1:0] ex_pc;
    logic          ex_branch;
    logic          ex_jump;
    logic          ex_branch_enable;
    logic          ex_predicted;
    logic          decision;
    logic          branch_jump_trigger;
    logic          mispredict;
    logic [SW-1:0] branch_cnt;
    logic [SW-1:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: counters as plain integers.
    int m_bht [NENT];
    int m_bcnt;
    int m_mcnt;

    branch_predictor_bht #(
        .PC_WIDTH   (PW),
        .INDEX_BITS (IB),
        .CNTR_BITS  (CB),
        .STAT_WIDTH (SW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .fetch_pc            (fetch_pc),
        .pred_taken          (pred_taken),
        .ex_valid            (ex_valid),
        .ex_pc               (ex_pc),
        .ex_branch           (ex_branch),
        .ex_jump             (ex_jump),
        .ex_branch_enable    (ex_branch_enable),
        .ex_predicted        (ex_predicted),
        .decision            (decision),
        .branch_jump_trigger (branch_jump_trigger),
        .mispredict          (mispredict),
        .branch_cnt          (branch_cnt),
        .mispredict_cnt      (mispredict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [PW-1:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic logic m_pred(input logic [PW-1:0] pc);
        return m_bht[m_idx(pc)] >= (1 << (CB - 1));
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NENT; i++) m_bht[i] = (1 << (CB - 1)) - 1;
        m_bcnt = 0;
        m_mcnt = 0;
    endfunction

    task automatic drive(input logic [PW-1:0] fpc, input logic v, input logic [PW-1:0] epc,
                         input logic br, input logic jp, input logic en, input logic pr);
        fetch_pc         = fpc;
        ex_valid         = v;
        ex_pc            = epc;
        ex_branch        = br;
        ex_jump          = jp;
        ex_branch_enable = en;
        ex_predicted     = pr;
    endtask

    // Check combinational outputs, clock once, advance the model, check stats.
    task automatic tick();
        logic dec, mis;
        int   i;
        #1;
        dec = ex_valid && ((ex_branch && ex_branch_enable) || ex_jump);
        mis = ex_valid && (ex_predicted != dec);
        chk("pred_taken", pred_taken, m_pred(fetch_pc));
        chk("decision", decision, dec);
        chk("bj_trigger", branch_jump_trigger, dec);
        chk("mispredict", mispredict, mis);
        @(posedge clk);
        if (!rst) begin
            if (ex_valid && ex_branch && !ex_jump) begin
                i = m_idx(ex_pc);
                if (ex_branch_enable) m_bht[i] = (m_bht[i] < CMAX) ? m_bht[i] + 1 : CMAX;
                else                  m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
                m_bcnt = (m_bcnt < SMAX) ? m_bcnt + 1 : SMAX;
            end
            if (mis) m_mcnt = (m_mcnt < SMAX) ? m_mcnt + 1 : SMAX;
        end
        #1;
        chk("branch_cnt", branch_cnt, m_bcnt);
        chk("mispredict_cnt", mispredict_cnt, m_mcnt);
    endtask

    // Look at the prediction for pc without training anything.
    task automatic peek(input logic [PW-1:0] pc);
        drive(pc, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    // Mid-cycle async reset; a training op is held on the EX inputs throughout.
    task automatic async_reset();
        #2;
        drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        m_reset();
        #1;
        chk("rst_branch_cnt", branch_cnt, 0);
        chk("rst_mispr_cnt", mispredict_cnt, 0);
        chk("rst_pred_now", pred_taken, 0);
        @(posedge clk);
        #1;
        chk("rst_no_train", pred_taken, 0);
        chk("rst_cnt_hold", branch_cnt, 0);
        rst = 1'b0;
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < NENT; i++) begin
            peek(PW'(i * 4));
            chk(tag, pred_taken, 0);
        end
    endtask

    initial begin
        logic [PW-1:0] p;
        rst = 1'b1;
        drive('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        chk("init_branch_cnt", branch_cnt, 0);
        chk("init_mispr_cnt", mispredict_cnt, 0);
        sweep_zero("init_sweep");

        // Saturation at pc 0x40.
        repeat (4) begin
            drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1);
            tick();
        end
        peek(32'h40);
        chk("sat_taken", pred_taken, 1);
        drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        peek(32'h40);
        chk("sat_one_nt", pred_taken, 1);
        drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        peek(32'h40);
        chk("sat_two_nt", pred_taken, 0);
        chk("sat_bcnt", branch_cnt, 6);

        // Aliasing: 0x100 and 0x000 share an entry, 0x104 does not.
        repeat (2) begin
            drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        peek(32'h100);
        chk("alias_100", pred_taken, 1);
        peek(32'h000);
        chk("alias_000", pred_taken, 1);
        peek(32'h104);
        chk("alias_104", pred_taken, 0);

        // Mispredicted taken branch, then the same with ex_valid low.
        async_reset();
        drive(32'h0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("mp_decision", decision, 1);
        chk("mp_mispredict", mispredict, 1);
        tick();
        chk("mp_cnt", mispredict_cnt, 1);
        drive(32'h0, 1'b0, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("inv_decision", decision, 0);
        chk("inv_trigger", branch_jump_trigger, 0);
        chk("inv_mispredict", mispredict, 0);
        tick();
        chk("inv_mcnt", mispredict_cnt, 1);
        chk("inv_bcnt", branch_cnt, 1);

        // Jump with branch also set: taken, mispredicted, no training.
        drive(32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("jmp_decision", decision, 1);
        chk("jmp_mispredict", mispredict, 1);
        tick();
        chk("jmp_bcnt", branch_cnt, 1);
        chk("jmp_mcnt", mispredict_cnt, 2);
        peek(32'h200);
        chk("jmp_bht_same", pred_taken, 1);

        // Collision: old value this cycle, new value next cycle.
        drive(32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("coll_old", pred_taken, 0);
        tick();
        peek(32'h80);
        chk("coll_new", pred_taken, 1);

        // Stat saturation with 4-bit counters.
        async_reset();
        repeat (20) begin
            drive($urandom, 1'b1, $urandom, 1'b1, 1'b0, 1'($urandom), 1'($urandom));
            tick();
        end
        chk("stat_sat", branch_cnt, 15);

        // Train strongly taken, then reset mid-run and sweep.
        repeat (3) begin
            drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1);
            tick();
        end
        async_reset();
        sweep_zero("mid_sweep");

        // Random traffic on a small PC window to force collisions.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                p = $urandom & 32'h1ff;
                drive(($urandom_range(0, 3) == 0) ? p : ($urandom & 32'h1ff),
                      $urandom_range(0, 4) != 0, p,
                      1'($urandom), $urandom_range(0, 5) == 0,
                      1'($urandom), 1'($urandom));
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
